// File: rtl/pacman_datapath.sv
// pacman_datapath: datapath partner of the game-control FSM.
// Holds player/ghost position, heading, move timer, score, animation frame,
// sticky game-over flag and the registered VGA plot request, and returns the
// status flags (timer_done, direction, wall/ghost collisions) to the FSM.
// Optional feature: define PACMAN_WRAP_EN to turn the X axis into a tunnel
// (walking off one side re-enters on the other; only Y can touch a wall).
module pacman_datapath #(
  parameter int          INIT_X    = 7,
  parameter int          INIT_Y    = 50,
  parameter int          STEP      = 1,
  parameter int          TICKS     = 2500000,
  parameter int          X_MIN     = 1,
  parameter int          X_MAX     = 158,
  parameter int          Y_MIN     = 1,
  parameter int          Y_MAX     = 118,
  parameter int          SPRITE    = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       en_x_position,
  input  logic [1:0] s_x_position,
  input  logic       en_y_position,
  input  logic [1:0] s_y_position,
  input  logic       en_direction,
  input  logic [1:0] s_direction,
  input  logic       en_timer,
  input  logic [1:0] s_timer,
  input  logic       move_index,
  input  logic       en_ghostRand,
  input  logic       s_score,
  input  logic       en_score,
  input  logic       s_game_over,
  input  logic [1:0] s_plot_color,
  input  logic       plot,
  output logic       timer_done,
  output logic [1:0] direction,
  output logic       touchingWall,
  output logic       touchingGhost,
  output logic       actuallybadGhost,
  output logic [7:0] x_pos,
  output logic [6:0] y_pos,
  output logic [7:0] ghost_x,
  output logic [6:0] ghost_y,
  output logic [9:0] score,
  output logic [1:0] anim_frame,
  output logic       game_over,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_color,
  output logic       vga_plot
);

  localparam int            TW         = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TICKS - 1);
  localparam logic [7:0]    INIT_X8    = 8'(INIT_X);
  localparam logic [7:0]    STEP_X     = 8'(STEP);
  localparam logic [7:0]    X_MIN8     = 8'(X_MIN);
  localparam logic [7:0]    X_MAX8     = 8'(X_MAX);
  localparam logic [6:0]    INIT_Y7    = 7'(INIT_Y);
  localparam logic [6:0]    STEP_Y     = 7'(STEP);
  localparam logic [6:0]    Y_MIN7     = 7'(Y_MIN);
  localparam logic [6:0]    Y_MAX7     = 7'(Y_MAX);
  localparam logic [8:0]    SPRITE9    = 9'(SPRITE);
  localparam logic [7:0]    GHOST_X0   = 8'(X_MAX / 2);
  localparam logic [6:0]    GHOST_Y0   = 7'(Y_MAX / 2);
`ifdef PACMAN_WRAP_EN
  localparam logic [7:0]    X_WRAP_HI  = 8'(X_MAX - STEP);
  localparam logic [7:0]    X_WRAP_LO  = 8'(X_MIN + STEP);
`endif

  logic [TW-1:0] timer_count;
  logic [15:0]   lfsr;
  logic          lfsr_fb;
  logic          key_up_q, key_down_q, key_left_q, key_right_q;
  logic          s_score_q;
  logic          y_out;
  logic          ghost_out;

  // Palette lookup for the plot colour select.
  function automatic logic [2:0] color_lut(input logic [1:0] sel);
    case (sel)
      2'd0:    return 3'b000;
      2'd1:    return 3'b110;
      2'd2:    return 3'b100;
      default: return 3'b111;
    endcase
  endfunction

  // Absolute distance between two unsigned coordinates.
  function automatic logic [8:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] d;
    d = signed'({1'b0, a}) - signed'({1'b0, b});
    return (d < 0) ? 9'($unsigned(-d)) : 9'($unsigned(d));
  endfunction

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Player X: load / step right / step left / hold (tunnel wrap optional).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) x_pos <= INIT_X8;
    else if (en_x_position) begin
      case (s_x_position)
        2'd0: x_pos <= INIT_X8;
`ifdef PACMAN_WRAP_EN
        2'd1: x_pos <= (x_pos > X_WRAP_HI) ? X_MIN8 : x_pos + STEP_X;
        2'd2: x_pos <= (x_pos < X_WRAP_LO) ? X_MAX8 : x_pos - STEP_X;
`else
        2'd1: x_pos <= x_pos + STEP_X;
        2'd2: x_pos <= x_pos - STEP_X;
`endif
        default: x_pos <= x_pos;
      endcase
    end
  end

  // Player Y: load / step down / step up / hold, modulo 7 bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) y_pos <= INIT_Y7;
    else if (en_y_position) begin
      case (s_y_position)
        2'd0:    y_pos <= INIT_Y7;
        2'd1:    y_pos <= y_pos + STEP_Y;
        2'd2:    y_pos <= y_pos - STEP_Y;
        default: y_pos <= y_pos;
      endcase
    end
  end

  // Heading: FSM force-right wins, else the highest-priority key that just rose.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      direction   <= 2'd3;
      key_up_q    <= 1'b0;
      key_down_q  <= 1'b0;
      key_left_q  <= 1'b0;
      key_right_q <= 1'b0;
    end else begin
      key_up_q    <= key_up;
      key_down_q  <= key_down;
      key_left_q  <= key_left;
      key_right_q <= key_right;
      if (en_direction && (s_direction == 2'd0)) direction <= 2'd3;
      else if (key_up    && !key_up_q)           direction <= 2'd0;
      else if (key_down  && !key_down_q)         direction <= 2'd1;
      else if (key_left  && !key_left_q)         direction <= 2'd2;
      else if (key_right && !key_right_q)        direction <= 2'd3;
    end
  end

  // Move timer: reload beats count; count parks at zero; done lags zero by one clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_count <= TIMER_LOAD;
      timer_done  <= 1'b0;
    end else if (en_timer && (s_timer == 2'd0)) begin
      timer_count <= TIMER_LOAD;
      timer_done  <= 1'b0;
    end else begin
      timer_done <= (timer_count == '0);
      if (en_timer && (s_timer == 2'd1) && (timer_count != '0))
        timer_count <= timer_count - 1'b1;
    end
  end

  // Free-running LFSR; ghost samples its current value on the strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr    <= LFSR_SEED;
      ghost_x <= GHOST_X0;
      ghost_y <= GHOST_Y0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
      if (en_ghostRand) begin
        ghost_x <= lfsr[7:0];
        ghost_y <= lfsr[14:8];
      end
    end
  end

  // Score: clear wins; otherwise count each rising edge of s_score, saturating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      score     <= 10'd0;
      s_score_q <= 1'b0;
    end else begin
      s_score_q <= s_score;
      if (en_score && s_score) score <= 10'd0;
      else if (!en_score && s_score && !s_score_q && (score != 10'h3FF))
        score <= score + 10'd1;
    end
  end

  // Animation frame and sticky game-over flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      anim_frame <= 2'd0;
      game_over  <= 1'b0;
    end else begin
      if (move_index)  anim_frame <= anim_frame + 2'd1;
      if (s_game_over) game_over  <= 1'b1;
    end
  end

  // Registered plot request: one-cycle strobe carrying the current position.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_plot  <= 1'b0;
      vga_x     <= 8'd0;
      vga_y     <= 7'd0;
      vga_color <= 3'd0;
    end else begin
      vga_plot <= plot;
      if (plot) begin
        vga_x     <= x_pos;
        vga_y     <= y_pos;
        vga_color <= color_lut(s_plot_color);
      end
    end
  end

  // Collision status is combinational on the current positions.
  assign y_out     = (y_pos < Y_MIN7) || (y_pos > Y_MAX7);
  assign ghost_out = (ghost_x < X_MIN8) || (ghost_x > X_MAX8) ||
                     (ghost_y < Y_MIN7) || (ghost_y > Y_MAX7);
`ifdef PACMAN_WRAP_EN
  assign touchingWall = y_out;
`else
  logic x_out;
  assign x_out        = (x_pos < X_MIN8) || (x_pos > X_MAX8);
  assign touchingWall = x_out || y_out;
`endif
  assign touchingGhost    = (abs_diff(x_pos, ghost_x) < SPRITE9) &&
                            (abs_diff({1'b0, y_pos}, {1'b0, ghost_y}) < SPRITE9);
  assign actuallybadGhost = ghost_out || touchingGhost;

endmodule

// File: tb/tb_pacman_datapath.sv
// Testbench for pacman_datapath: directed vectors, an abstract reference
// model checked every cycle, and hand-computed literal expectations.
module tb_pacman_datapath;

  localparam int TICKS = 4;
  localparam int X_MIN = 1, X_MAX = 158, Y_MIN = 1, Y_MAX = 118;
  localparam int STEP = 1, SPRITE = 4;
  localparam int SEED = 'h3214;  // ghost sample at first edge = (20,50)

  logic clk = 1'b0, reset_n = 1'b0;
  logic key_up = 0, key_down = 0, key_left = 0, key_right = 0;
  logic en_x_position = 0, en_y_position = 0, en_direction = 0, en_timer = 0;
  logic [1:0] s_x_position = 0, s_y_position = 0, s_direction = 0, s_timer = 0, s_plot_color = 0;
  logic move_index = 0, en_ghostRand = 0, s_score = 0, en_score = 0, s_game_over = 0, plot = 0;
  logic timer_done, touchingWall, touchingGhost, actuallybadGhost, game_over, vga_plot;
  logic [1:0] direction, anim_frame;
  logic [7:0] x_pos, ghost_x, vga_x;
  logic [6:0] y_pos, ghost_y, vga_y;
  logic [9:0] score;
  logic [2:0] vga_color;

  int tests = 0, fails = 0;

  pacman_datapath #(.TICKS(TICKS), .LFSR_SEED(16'(SEED))) dut (
    .clk(clk), .reset_n(reset_n),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .en_x_position(en_x_position), .s_x_position(s_x_position),
    .en_y_position(en_y_position), .s_y_position(s_y_position),
    .en_direction(en_direction), .s_direction(s_direction),
    .en_timer(en_timer), .s_timer(s_timer), .move_index(move_index),
    .en_ghostRand(en_ghostRand), .s_score(s_score), .en_score(en_score),
    .s_game_over(s_game_over), .s_plot_color(s_plot_color), .plot(plot),
    .timer_done(timer_done), .direction(direction), .touchingWall(touchingWall),
    .touchingGhost(touchingGhost), .actuallybadGhost(actuallybadGhost),
    .x_pos(x_pos), .y_pos(y_pos), .ghost_x(ghost_x), .ghost_y(ghost_y),
    .score(score), .anim_frame(anim_frame), .game_over(game_over),
    .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int mx, my, mdir, mcnt, mdone, ml, mgx, mgy, mscore, msprev, manim, mgo;
  int mvx, mvy, mvc, mvp;
  int kprev[4];

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic int pal(input int s);
    case (s)
      0: return 0;
      1: return 6;
      2: return 4;
      default: return 7;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mx = 7; my = 50; mdir = 3; mcnt = TICKS - 1; mdone = 0; ml = SEED;
      mgx = X_MAX / 2; mgy = Y_MAX / 2; mscore = 0; msprev = 0; manim = 0; mgo = 0;
      mvx = 0; mvy = 0; mvc = 0; mvp = 0;
      for (int i = 0; i < 4; i++) kprev[i] = 0;
    end else begin
      int fb;
      int k[4];
      // plot and ghost capture use values from before this edge
      mvp = plot;
      if (plot) begin mvx = mx; mvy = my; mvc = pal(s_plot_color); end
      if (en_ghostRand) begin mgx = ml % 256; mgy = (ml / 256) % 128; end
      fb = ((ml >> 15) ^ (ml >> 13) ^ (ml >> 12) ^ (ml >> 10)) & 1;
      ml = ((ml * 2) + fb) % 65536;
      if (en_x_position) begin
        case (s_x_position)
          0: mx = 7;
`ifdef PACMAN_WRAP_EN
          1: mx = (mx + STEP > X_MAX) ? X_MIN : mx + STEP;
          2: mx = (mx - STEP < X_MIN) ? X_MAX : mx - STEP;
`else
          1: mx = (mx + STEP) % 256;
          2: mx = (mx - STEP + 256) % 256;
`endif
          default: ;
        endcase
      end
      if (en_y_position) begin
        case (s_y_position)
          0: my = 50;
          1: my = (my + STEP) % 128;
          2: my = (my - STEP + 128) % 128;
          default: ;
        endcase
      end
      k[0] = key_up; k[1] = key_down; k[2] = key_left; k[3] = key_right;
      if (en_direction && s_direction == 0) mdir = 3;
      else begin
        for (int i = 3; i >= 0; i--) if (k[i] && !kprev[i]) mdir = i;
      end
      for (int i = 0; i < 4; i++) kprev[i] = k[i];
      if (en_timer && s_timer == 0) begin mcnt = TICKS - 1; mdone = 0; end
      else begin
        mdone = (mcnt == 0);
        if (en_timer && s_timer == 1 && mcnt > 0) mcnt--;
      end
      if (en_score && s_score) mscore = 0;
      else if (!en_score && s_score && !msprev && mscore < 1023) mscore++;
      msprev = s_score;
      if (move_index) manim = (manim + 1) % 4;
      if (s_game_over) mgo = 1;
    end
  end

  // Compare process: every cycle out of reset, away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      int xo, yo, go, tg, wall;
      xo = (mx < X_MIN || mx > X_MAX);
      yo = (my < Y_MIN || my > Y_MAX);
      go = (mgx < X_MIN || mgx > X_MAX || mgy < Y_MIN || mgy > Y_MAX);
      tg = (iabs(mx - mgx) < SPRITE) && (iabs(my - mgy) < SPRITE);
`ifdef PACMAN_WRAP_EN
      wall = yo;
`else
      wall = xo || yo;
`endif
      check("m_x", x_pos, mx);          check("m_y", y_pos, my);
      check("m_ghost_x", ghost_x, mgx); check("m_ghost_y", ghost_y, mgy);
      check("m_dir", direction, mdir);  check("m_timer_done", timer_done, mdone);
      check("m_score", score, mscore);  check("m_anim", anim_frame, manim);
      check("m_game_over", game_over, mgo);
      check("m_vga_plot", vga_plot, mvp); check("m_vga_x", vga_x, mvx);
      check("m_vga_y", vga_y, mvy);     check("m_vga_color", vga_color, mvc);
      check("m_wall", touchingWall, wall);
      check("m_tghost", touchingGhost, tg);
      check("m_badghost", actuallybadGhost, go || tg);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_x"}, x_pos, 7);        check({tag, "_y"}, y_pos, 50);
    check({tag, "_dir"}, direction, 3);  check({tag, "_score"}, score, 0);
    check({tag, "_timer_done"}, timer_done, 0);
    check({tag, "_vga_plot"}, vga_plot, 0);
    check({tag, "_game_over"}, game_over, 0);
  endtask

  initial begin
    // reset with the ghost strobe already asserted so the first edge samples the seed
    en_ghostRand = 1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    check_reset_state("rst");
    check("rst_ghost_x", ghost_x, 79);
    check("rst_ghost_y", ghost_y, 59);
    step(1);
    en_ghostRand = 0;
    check("seed_ghost_x", ghost_x, 20);
    check("seed_ghost_y", ghost_y, 50);

    // timer: reload then count TICKS cycles
    en_timer = 1; s_timer = 0; step(1);
    s_timer = 1; step(3);
    check("timer_3cnt", timer_done, 0);
    step(1);
    check("timer_4cnt", timer_done, 1);
    en_timer = 0; step(2);
    check("timer_hold", timer_done, 1);
    en_timer = 1; s_timer = 0; step(1);
    check("timer_reload", timer_done, 0);
    en_timer = 0;

    // ghost collision around ghost (20,50)
    en_x_position = 1; s_x_position = 1; step(11); en_x_position = 0;
    en_y_position = 1; s_y_position = 1; step(2);  en_y_position = 0;
    check("col_x18", x_pos, 18); check("col_y52", y_pos, 52);
    check("tg_x18", touchingGhost, 1); check("bad_x18", actuallybadGhost, 1);
    en_x_position = 1; step(5); en_x_position = 0;
    check("tg_x23", touchingGhost, 1);
    en_x_position = 1; step(1); en_x_position = 0;
    check("tg_x24", touchingGhost, 0); check("bad_x24", actuallybadGhost, 0);

    // right edge
    en_x_position = 1; step(134); en_x_position = 0;
    check("edge_x158", x_pos, 158); check("wall_x158", touchingWall, 0);
    en_x_position = 1; step(1); en_x_position = 0;
`ifdef PACMAN_WRAP_EN
    check("wrap_hi_x", x_pos, 1);   check("wrap_hi_wall", touchingWall, 0);
`else
    check("over_hi_x", x_pos, 159); check("over_hi_wall", touchingWall, 1);
`endif
    // left edge
    en_x_position = 1; s_x_position = 0; step(1);
    s_x_position = 2; step(6); en_x_position = 0;
    check("edge_x1", x_pos, 1); check("wall_x1", touchingWall, 0);
    en_x_position = 1; step(1); en_x_position = 0;
`ifdef PACMAN_WRAP_EN
    check("wrap_lo_x", x_pos, 158); check("wrap_lo_wall", touchingWall, 0);
`else
    check("under_lo_x", x_pos, 0);  check("under_lo_wall", touchingWall, 1);
`endif
    en_x_position = 1; s_x_position = 0; step(1); en_x_position = 0;

    // score edge counting and clear
    s_score = 1; step(3); check("score_run", score, 1);
    s_score = 0; step(1);
    s_score = 1; step(1); check("score_2nd", score, 2);
    s_score = 0; step(1);
    en_score = 1; s_score = 1; step(1); check("score_clr", score, 0);
    en_score = 0; s_score = 0; step(1);

    // re-sample ghost from a running LFSR (checked by the model)
    en_ghostRand = 1; step(1); en_ghostRand = 0; step(1);

    // heading
    key_left = 1; key_up = 1; step(1); check("dir_up_wins", direction, 0);
    key_left = 0; key_up = 0; step(1);
    key_right = 1; step(1); check("dir_right", direction, 3);
    key_right = 0; key_down = 1; step(1); check("dir_down", direction, 1);
    key_down = 0; step(1);
    en_direction = 1; s_direction = 0; key_up = 1; step(1);
    check("dir_force", direction, 3);
    en_direction = 0; key_up = 0; step(1);

    // plot request
    plot = 1; s_plot_color = 1; step(1); plot = 0;
    check("plot_strobe", vga_plot, 1); check("plot_yellow", vga_color, 6);
    check("plot_x", vga_x, 7); check("plot_y", vga_y, 52);
    step(1); check("plot_one_clk", vga_plot, 0);
    plot = 1; s_plot_color = 2; step(1); plot = 0;
    check("plot_red", vga_color, 4);

    // animation and game over
    move_index = 1; step(5); move_index = 0;
    check("anim_wrap", anim_frame, 1);
    s_game_over = 1; step(1); s_game_over = 0; step(2);
    check("game_over_sticky", game_over, 1);

    // reset in the middle of a count and a move
    en_timer = 1; s_timer = 0; step(1); s_timer = 1;
    en_x_position = 1; s_x_position = 1; plot = 1; step(4);
    check("pre_rst_done", timer_done, 1);
    reset_n = 0;
    #2 check_reset_state("mid_rst");
    en_timer = 0; s_timer = 0; en_x_position = 0; s_x_position = 0; plot = 0;
    step(1);
    reset_n = 1;
    step(1);
    check_reset_state("post_rst");
    step(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound so the run can never hang.
  initial begin
    #200000;
    fails++;
    $display("FAIL timeout: simulation exceeded time budget");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
